// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the mux select arbiter and its gap timer.
package mux_sel_pkg;

  localparam int unsigned GAP_W  = 4;
  localparam int unsigned BEAT_W = 8;

  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    GRANT1 = 2'd2,
    GRANT2 = 2'd3
  } state_t;

endpackage

// File: rtl/mux_sel_gap_timer.sv
// Loadable down-counter; done_c is high while the count is zero.
import mux_sel_pkg::*;

module mux_sel_gap_timer #(
  parameter int unsigned W = GAP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done_c
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Select generator for a 2:1 mux bank: packet-locked arbitration with idle gaps on S changes.
// Optional per-grant beat limit enabled by defining MUX_SEL_BURST_LIMIT_EN.
import mux_sel_pkg::*;

module mux_sel_arbiter #(
  parameter int unsigned SWITCH_GAP = 1,
  parameter int unsigned MAX_BEATS  = 8
) (
  input  logic CLK,
  input  logic RSTB,
  input  logic VALID1,
  input  logic LAST1,
  output logic GNT1,
  input  logic VALID2,
  input  logic LAST2,
  output logic GNT2,
  output logic S,
  output logic OUT_VALID,
  input  logic OUT_READY,
  output logic OUT_LAST,
  output logic BUSY
);

  localparam int unsigned GAP_M1 = (SWITCH_GAP == 0) ? 0 : SWITCH_GAP - 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_M1);
  localparam bit NO_GAP = (SWITCH_GAP == 0);

  state_t state_q, state_d;
  logic   sel_q, sel_d;
  logic   lw_q, lw_d;
  logic   gap_load, gap_dec, gap_done;
  logic   beat_clr, beat_inc, burst_hit;
  logic   tgt, cur_valid, cur_last, cur_other, cur_sel, xfer;

  // Tie-break favours the source that did not win last.
  assign tgt       = (VALID1 && VALID2) ? ~lw_q : (VALID1 ? SEL_IN1 : SEL_IN2);
  assign cur_valid = (state_q == GRANT2) ? VALID2 : VALID1;
  assign cur_last  = (state_q == GRANT2) ? LAST2  : LAST1;
  assign cur_other = (state_q == GRANT2) ? VALID1 : VALID2;
  assign cur_sel   = (state_q == GRANT2) ? SEL_IN2 : SEL_IN1;

  mux_sel_gap_timer #(.W(GAP_W)) u_gap (
    .clk      (CLK),
    .rst_n    (RSTB),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .done_c   (gap_done)
  );

`ifdef MUX_SEL_BURST_LIMIT_EN
  logic [BEAT_W-1:0] beat_cnt_q;

  // Saturating count of transfers within the current grant.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      beat_cnt_q <= '0;
    end else if (beat_clr) begin
      beat_cnt_q <= '0;
    end else if (beat_inc && (beat_cnt_q < BEAT_W'(MAX_BEATS))) begin
      beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
    end
  end

  assign burst_hit = (beat_cnt_q >= BEAT_W'(MAX_BEATS - 1)) && cur_other;
`else
  logic unused_burst;
  assign unused_burst = beat_clr ^ beat_inc ^ cur_other ^ (MAX_BEATS == 0);
  assign burst_hit    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= IDLE;
      sel_q   <= SEL_IN1;
      lw_q    <= SEL_IN2;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      lw_q    <= lw_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    lw_d      = lw_q;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    beat_clr  = 1'b0;
    beat_inc  = 1'b0;
    xfer      = 1'b0;
    GNT1      = 1'b0;
    GNT2      = 1'b0;
    OUT_VALID = 1'b0;
    OUT_LAST  = 1'b0;
    case (state_q)
      IDLE: begin
        if (VALID1 || VALID2) begin
          sel_d = tgt;
          if ((tgt == sel_q) || NO_GAP) begin
            state_d  = (tgt == SEL_IN1) ? GRANT1 : GRANT2;
            beat_clr = 1'b1;
          end else begin
            state_d  = GAP;
            gap_load = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_done) begin
          state_d  = (sel_q == SEL_IN1) ? GRANT1 : GRANT2;
          beat_clr = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      GRANT1, GRANT2: begin
        OUT_VALID = cur_valid;
        OUT_LAST  = cur_last;
        xfer      = cur_valid && OUT_READY;
        GNT1      = xfer && (state_q == GRANT1);
        GNT2      = xfer && (state_q == GRANT2);
        beat_inc  = xfer;
        if (xfer && (cur_last || burst_hit)) begin
          state_d = IDLE;
          lw_d    = cur_sel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign S    = sel_q;
  assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: vector table, directed corner sequences, random vs model.
module tb_mux_sel_arbiter;

  localparam int unsigned GAP  = 2;
  localparam int unsigned MAXB = 4;

  logic CLK = 1'b0;
  logic RSTB, VALID1, LAST1, VALID2, LAST2, OUT_READY;
  logic GNT1, GNT2, S, OUT_VALID, OUT_LAST, BUSY;

  always #5 CLK = ~CLK;

  mux_sel_arbiter #(.SWITCH_GAP(GAP), .MAX_BEATS(MAXB)) dut (
    .CLK(CLK), .RSTB(RSTB),
    .VALID1(VALID1), .LAST1(LAST1), .GNT1(GNT1),
    .VALID2(VALID2), .LAST2(LAST2), .GNT2(GNT2),
    .S(S), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_LAST(OUT_LAST), .BUSY(BUSY)
  );

  int checks = 0;
  int failures = 0;
  int gq[$];

  // Model: phase 0 idle, 1 gap, 2 granted; who = 1/2; sel = current select.
  int m_phase, m_who, m_sel, m_lastw, m_gap, m_beats;

  typedef struct {
    logic [4:0] in;   // {v1,l1,v2,l2,rdy}
    logic [5:0] exp;  // {gnt1,gnt2,ov,ol&ov,s,busy}
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] dut_out();
    return {GNT1, GNT2, OUT_VALID, OUT_LAST & OUT_VALID, S, BUSY};
  endfunction

  function automatic logic [5:0] model_out();
    logic vx, lx;
    vx = (m_who == 1) ? VALID1 : VALID2;
    lx = (m_who == 1) ? LAST1 : LAST2;
    return {(m_phase == 2) && (m_who == 1) && vx && OUT_READY,
            (m_phase == 2) && (m_who == 2) && vx && OUT_READY,
            (m_phase == 2) && vx,
            (m_phase == 2) && vx && lx,
            1'(m_sel),
            m_phase != 0};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_who = 1; m_sel = 0; m_lastw = 2; m_gap = 0; m_beats = 0;
  endtask

  task automatic model_step(input logic v1, l1, v2, l2, rdy);
    int t, ns;
    logic vx, lx, ox;
    case (m_phase)
      0: if (v1 || v2) begin
        t  = (v1 && v2) ? ((m_lastw == 1) ? 2 : 1) : (v1 ? 1 : 2);
        ns = t - 1;
        m_who = t;
        if (ns == m_sel || GAP == 0) begin m_phase = 2; m_beats = 0; end
        else begin m_phase = 1; m_gap = GAP; end
        m_sel = ns;
      end
      1: begin
        m_gap--;
        if (m_gap == 0) begin m_phase = 2; m_beats = 0; end
      end
      default: begin
        vx = (m_who == 1) ? v1 : v2;
        lx = (m_who == 1) ? l1 : l2;
        ox = (m_who == 1) ? v2 : v1;
        if (vx && rdy) begin
          m_beats++;
          if (lx) begin m_phase = 0; m_lastw = m_who; end
`ifdef MUX_SEL_BURST_LIMIT_EN
          else if (m_beats >= MAXB && ox) begin m_phase = 0; m_lastw = m_who; end
`endif
        end
      end
    endcase
  endtask

  task automatic tick(input logic v1, l1, v2, l2, rdy, input string name);
    @(negedge CLK);
    VALID1 = v1; LAST1 = l1; VALID2 = v2; LAST2 = l2; OUT_READY = rdy;
    #1;
    check(name, 32'(dut_out()), 32'(model_out()));
    if (GNT1) gq.push_back(1);
    if (GNT2) gq.push_back(2);
    @(posedge CLK);
    model_step(v1, l1, v2, l2, rdy);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTB = 1'b0;
    VALID1 = 0; LAST1 = 0; VALID2 = 0; LAST2 = 0; OUT_READY = 0;
    repeat (2) @(negedge CLK);
    RSTB = 1'b1;
    model_reset();
    gq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[11];
    int run1, idx;
    bit found, resumed;

    vt[0]  = '{5'b00001, 6'b000000};  // reset state, idle
    vt[1]  = '{5'b11001, 6'b000000};  // src1 request, same leg
    vt[2]  = '{5'b11001, 6'b101101};  // granted after 1 cycle, single LAST beat
    vt[3]  = '{5'b00001, 6'b000000};  // back to idle, no gap
    vt[4]  = '{5'b00101, 6'b000000};  // src2 request, leg change
    vt[5]  = '{5'b00101, 6'b000011};  // gap 1, S already 1
    vt[6]  = '{5'b00101, 6'b000011};  // gap 2
    vt[7]  = '{5'b00101, 6'b011011};  // beat 1
    vt[8]  = '{5'b00101, 6'b011011};  // beat 2
    vt[9]  = '{5'b00111, 6'b011111};  // beat 3 with LAST
    vt[10] = '{5'b00001, 6'b000010};  // idle, S held at 1

    RSTB = 1'b0;
    VALID1 = 0; LAST1 = 0; VALID2 = 0; LAST2 = 0; OUT_READY = 0;
    #12;
    check("reset_busy", 32'(BUSY), 32'(0));
    check("reset_s", 32'(S), 32'(0));
    do_reset();

    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      {VALID1, LAST1, VALID2, LAST2, OUT_READY} = vt[i].in;
      #1;
      check($sformatf("vec%0d", i), 32'(dut_out()), 32'(vt[i].exp));
    end

    // Alternation of single-beat packets with both sources always valid.
    do_reset();
    for (int i = 0; i < 20; i++) tick(1, 1, 1, 1, 1, "alt");
    check("alt_count_ge4", 32'(gq.size() >= 4), 32'(1));
    for (int i = 0; i < 4; i++)
      if (i < gq.size()) check($sformatf("alt_order%0d", i), 32'(gq[i]), 32'((i % 2) + 1));

    // Stall mid-packet in GRANT1 with the other source pending.
    do_reset();
    tick(1, 0, 0, 0, 1, "stall_req");
    tick(1, 0, 0, 0, 1, "stall_beat1");
    gq.delete();
    for (int i = 0; i < 4; i++) tick(1, 0, 1, 0, 0, "stall_hold");
    check("stall_no_grant", 32'(gq.size()), 32'(0));
    check("stall_s", 32'(S), 32'(0));
    tick(1, 1, 1, 1, 1, "stall_last");
    tick(0, 0, 1, 1, 1, "stall_idle");
    tick(0, 0, 1, 1, 1, "stall_switch");
    check("stall_s_after", 32'(S), 32'(1));

    // Asynchronous reset in the middle of a source-2 packet.
    do_reset();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(0, 0, 1, 0, 1, "rst_reach");
      found = (gq.size() != 0);
    end
    check("rst_reach_grant2", 32'(found), 32'(1));
    @(negedge CLK);
    VALID2 = 1; LAST2 = 0; OUT_READY = 1;
    #1;
    check("rst_pre_gnt2", 32'(GNT2), 32'(1));
    RSTB = 1'b0;
    #1;
    check("rst_gnt2", 32'(GNT2), 32'(0));
    check("rst_out_valid", 32'(OUT_VALID), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(0));
    check("rst_s", 32'(S), 32'(0));
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      tick(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 35),
           1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 35),
           1'($urandom_range(0, 99) < 75), "rand");

`ifdef MUX_SEL_BURST_LIMIT_EN
    // Long source-1 packet released after MAXB beats while source 2 waits.
    do_reset();
    for (int i = 0; i < 40; i++) tick(1, 0, 1, 1, 1, "burst");
    run1 = 0; idx = 0;
    while (idx < gq.size() && gq[idx] == 1) begin run1++; idx++; end
    check("burst_run1", 32'(run1), 32'(MAXB));
    check("burst_src2", 32'(idx < gq.size()), 32'(1));
    resumed = 0;
    for (int i = idx; i < gq.size(); i++) if (gq[i] == 1) resumed = 1;
    check("burst_resume", 32'(resumed), 32'(1));
`else
    run1 = 0; idx = 0; resumed = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
